// File: rtl/pid_pkg.sv
// Shared widths, types and defaults for the heading PID front stage.
package pid_pkg;

  localparam int unsigned HDNG_W  = 12;
  localparam int unsigned ERR_W   = 10;
  localparam int unsigned DIFF_W  = 11;
  localparam int unsigned DSAT_W  = 7;
  localparam int unsigned DTERM_W = 13;
  localparam int unsigned CNT_W   = 3;

  localparam logic signed [5:0] D_COEFF_DFLT = 6'sd11;

  typedef logic signed [ERR_W-1:0]   err_t;
  typedef logic signed [DTERM_W-1:0] dterm_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } dterm_state_t;

endpackage

// File: rtl/sat_signed.sv
// Combinational signed clamp from IN_W bits down to OUT_W bits (IN_W > OUT_W).
module sat_signed #(
  parameter int unsigned IN_W  = 13,
  parameter int unsigned OUT_W = 10
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [IN_W-1:0] MAXV = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MINV = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Pass through when in range, otherwise pin to the nearest limit
  always_comb begin
    dout = din[OUT_W-1:0];
    if (din > MAXV) begin
      dout = MAXV[OUT_W-1:0];
    end else if (din < MINV) begin
      dout = MINV[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/hdng_err_dterm.sv
// Heading PID front stage: saturated heading error and derivative term.
module hdng_err_dterm
  import pid_pkg::*;
#(
  parameter int unsigned       D_DEPTH = 2,
  parameter logic signed [5:0] D_COEFF = D_COEFF_DFLT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      moving,
  input  logic                      hdng_vld_in,
  input  logic signed [HDNG_W-1:0]  actl_hdng,
  input  logic signed [HDNG_W-1:0]  dsrd_hdng,
  output logic signed [ERR_W-1:0]   err_sat,
  output logic                      hdng_vld,
  output logic signed [DTERM_W-1:0] D_term,
  output logic                      d_vld
);

  dterm_state_t             state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  err_t                     hist_q [D_DEPTH];
  err_t                     hist_d [D_DEPTH];
  err_t                     err_sat_q, err_sat_d;
  logic                     hdng_vld_q, hdng_vld_d;
  dterm_t                   dterm_q, dterm_d;
  logic                     d_vld_q, d_vld_d;

  logic signed [HDNG_W:0]   err_full;
  err_t                     err_clamped;
  logic signed [DIFF_W-1:0] diff;
  logic signed [DSAT_W-1:0] d_sat;
  dterm_t                   d_prod;

  assign err_full = {actl_hdng[HDNG_W-1], actl_hdng} - {dsrd_hdng[HDNG_W-1], dsrd_hdng};
  assign diff     = {err_sat_q[ERR_W-1], err_sat_q} - {hist_q[D_DEPTH-1][ERR_W-1], hist_q[D_DEPTH-1]};
  assign d_prod   = dterm_t'(d_sat) * dterm_t'(D_COEFF);

  sat_signed #(.IN_W(HDNG_W + 1), .OUT_W(ERR_W)) u_err_sat (
    .din  (err_full),
    .dout (err_clamped)
  );

  sat_signed #(.IN_W(DIFF_W), .OUT_W(DSAT_W)) u_diff_sat (
    .din  (diff),
    .dout (d_sat)
  );

  // Stage 1: capture the saturated error on every valid heading sample
  always_comb begin
    err_sat_d  = err_sat_q;
    hdng_vld_d = hdng_vld_in;
    if (hdng_vld_in) begin
      err_sat_d = err_clamped;
    end
  end

  // Stage 2 and FSM: flush on !moving takes priority over any pending sample
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hist_d  = hist_q;
    dterm_d = dterm_q;
    d_vld_d = hdng_vld_q;
    if (!moving) begin
      state_d = IDLE;
      cnt_d   = '0;
      for (int unsigned i = 0; i < D_DEPTH; i++) hist_d[i] = '0;
      if (hdng_vld_q) dterm_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = FILL;
          if (hdng_vld_q) dterm_d = '0;
        end
        FILL: begin
          if (hdng_vld_q) begin
            dterm_d   = '0;
            hist_d[0] = err_sat_q;
            for (int unsigned i = 1; i < D_DEPTH; i++) hist_d[i] = hist_q[i-1];
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_W'(D_DEPTH)) state_d = RUN;
          end
        end
        RUN: begin
          if (hdng_vld_q) begin
            dterm_d   = d_prod;
            hist_d[0] = err_sat_q;
            for (int unsigned i = 1; i < D_DEPTH; i++) hist_d[i] = hist_q[i-1];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      for (int unsigned i = 0; i < D_DEPTH; i++) hist_q[i] <= '0;
      err_sat_q  <= '0;
      hdng_vld_q <= 1'b0;
      dterm_q    <= '0;
      d_vld_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hist_q     <= hist_d;
      err_sat_q  <= err_sat_d;
      hdng_vld_q <= hdng_vld_d;
      dterm_q    <= dterm_d;
      d_vld_q    <= d_vld_d;
    end
  end

  assign err_sat  = err_sat_q;
  assign hdng_vld = hdng_vld_q;
  assign D_term   = dterm_q;
  assign d_vld    = d_vld_q;

endmodule

// File: tb/tb_hdng_err_dterm.sv
// Directed self-checking bench for hdng_err_dterm.
module tb_hdng_err_dterm;
  import pid_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               moving;
  logic               hdng_vld_in;
  logic signed [11:0] actl_hdng;
  logic signed [11:0] dsrd_hdng;
  logic signed [9:0]  err_sat;
  logic               hdng_vld;
  logic signed [12:0] D_term;
  logic               d_vld;

  int checks = 0;
  int errors = 0;

  hdng_err_dterm #(.D_DEPTH(2), .D_COEFF(6'sd11)) dut (
    .clk         (clk),
    .rst         (rst),
    .moving      (moving),
    .hdng_vld_in (hdng_vld_in),
    .actl_hdng   (actl_hdng),
    .dsrd_hdng   (dsrd_hdng),
    .err_sat     (err_sat),
    .hdng_vld    (hdng_vld),
    .D_term      (D_term),
    .d_vld       (d_vld)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [15:0] obs, input logic signed [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One isolated sample: check stage 1 at E and stage 2 at E+1
  task automatic pulse(input string tag, input int a, input int d, input int exp_err, input int exp_d);
    actl_hdng   = 12'(a);
    dsrd_hdng   = 12'(d);
    hdng_vld_in = 1'b1;
    tick();
    chk({tag, ".hv"}, 16'(hdng_vld), 16'sd1);
    chk({tag, ".err"}, 16'(err_sat), 16'(exp_err));
    chk({tag, ".dv0"}, 16'(d_vld), 16'sd0);
    hdng_vld_in = 1'b0;
    tick();
    chk({tag, ".hv0"}, 16'(hdng_vld), 16'sd0);
    chk({tag, ".dv"}, 16'(d_vld), 16'sd1);
    chk({tag, ".dt"}, 16'(D_term), 16'(exp_d));
  endtask

  initial begin
    int hv_cnt;
    int dv_cnt;
    rst = 1'b1; moving = 1'b0; hdng_vld_in = 1'b0; actl_hdng = '0; dsrd_hdng = '0;
    tick(); tick();
    chk("rst.err", 16'(err_sat), 16'sd0);
    chk("rst.hv", 16'(hdng_vld), 16'sd0);
    chk("rst.dt", 16'(D_term), 16'sd0);
    chk("rst.dv", 16'(d_vld), 16'sd0);
    rst = 1'b0;
    tick();

    // Error saturation (not moving: D_term forced to 0)
    pulse("sat_pos", 'h3FF, 0, 511, 0);
    pulse("sat_neg", -1024, 1023, -512, 0);
    pulse("small", 5, 12, -7, 0);

    // Derivative ramp
    moving = 1'b1;
    tick(); tick();
    pulse("ramp0", 10, 0, 10, 0);
    pulse("ramp1", 20, 0, 20, 0);
    pulse("ramp2", 30, 0, 30, 220);

    // Derivative saturation, both directions (history continues from ramp)
    pulse("dsat0", -512, 0, -512, -704);
    pulse("dsat1", 0, 0, 0, -330);
    pulse("dsat2", 511, 0, 511, 693);
    pulse("rsat0", 511, 0, 511, 693);
    pulse("rsat1", 0, 0, 0, -704);
    pulse("rsat2", -512, 0, -512, -704);

    // moving falls on the same edge as the stage-2 sample
    actl_hdng = 12'sd77; dsrd_hdng = '0; hdng_vld_in = 1'b1;
    tick();
    chk("flush.err", 16'(err_sat), 16'sd77);
    hdng_vld_in = 1'b0; moving = 1'b0;
    tick();
    chk("flush.dv", 16'(d_vld), 16'sd1);
    chk("flush.dt", 16'(D_term), 16'sd0);
    chk("flush.state", 16'(dut.state_q), 16'(IDLE));
    moving = 1'b1;
    tick(); tick();
    pulse("refill0", 40, 0, 40, 0);
    pulse("refill1", 50, 0, 50, 0);
    pulse("refill2", 60, 0, 60, 220);

    // Back-to-back samples after a fresh flush
    moving = 1'b0; tick();
    moving = 1'b1; tick(); tick();
    hv_cnt = 0; dv_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      actl_hdng = 12'(100 + 10 * k); hdng_vld_in = 1'b1;
      tick();
      hv_cnt += int'(hdng_vld);
      dv_cnt += int'(d_vld);
      chk($sformatf("tp%0d.err", k), 16'(err_sat), 16'(100 + 10 * k));
      chk($sformatf("tp%0d.dv", k), 16'(d_vld), (k > 0) ? 16'sd1 : 16'sd0);
      if (k > 0) chk($sformatf("tp%0d.dt", k), 16'(D_term), (k - 1 < 2) ? 16'sd0 : 16'sd220);
    end
    hdng_vld_in = 1'b0;
    tick();
    hv_cnt += int'(hdng_vld);
    dv_cnt += int'(d_vld);
    chk("tp_last.dt", 16'(D_term), 16'sd220);
    tick();
    hv_cnt += int'(hdng_vld);
    dv_cnt += int'(d_vld);
    chk("tp.hv_count", 16'(hv_cnt), 16'sd8);
    chk("tp.dv_count", 16'(dv_cnt), 16'sd8);

    // Reset mid-RUN, held for 2 cycles with a sample pending
    chk("pre_rst.state", 16'(dut.state_q), 16'(RUN));
    actl_hdng = 12'sd300; hdng_vld_in = 1'b1; rst = 1'b1;
    tick(); tick();
    chk("mrst.err", 16'(err_sat), 16'sd0);
    chk("mrst.hv", 16'(hdng_vld), 16'sd0);
    chk("mrst.dt", 16'(D_term), 16'sd0);
    chk("mrst.dv", 16'(d_vld), 16'sd0);
    chk("mrst.state", 16'(dut.state_q), 16'(IDLE));
    hdng_vld_in = 1'b0; rst = 1'b0;
    tick(); tick();
    pulse("post0", 25, 0, 25, 0);
    pulse("post1", 35, 0, 35, 0);
    pulse("post2", 45, 0, 45, 220);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
